// File: rtl/lsu_bus_bridge_pkg.sv
// Shared funct3 codes, FSM state encoding and the access-fault rule for the LSU bus bridge.
package lsu_bus_bridge_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    // Reserved funct3 codes and accesses not naturally aligned to their size never reach the bus.
    function automatic logic is_fault(input logic [2:0] f3, input logic [1:0] off);
        logic flt;
        case (f3)
            F3_B, F3_BU: flt = 1'b0;
            F3_H, F3_HU: flt = off[0];
            F3_W:        flt = (off != 2'b00);
            default:     flt = 1'b1;
        endcase
        return flt;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: store byte enables / lane replication and load byte/half selection with extension.
// Zero latency; no flow control of its own.
module lsu_lane_align
    import lsu_bus_bridge_pkg::*;
(
    input  logic [2:0]  st_f3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_f3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_f3)
            F3_B, F3_BU: begin
                st_be    = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            F3_H, F3_HU: begin
                st_be    = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    // Halfword lane follows addr[1] only; addr[0] is already excluded by the fault check.
    always_comb begin
        ld_byte = ld_word[{ld_off, 3'b000} +: 8];
        ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_f3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge: one word-aligned valid/ready bus transaction per core access, formatted ReadData back.
// Latency: IDLE + BUS (+1 per ready wait) stall cycles, then one DONE release cycle.
// Backpressure: holds bus_* stable until bus_ready or TIMEOUT; core is stalled throughout.
module lsu_bus_bridge
    import lsu_bus_bridge_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    lsu_state_t      state;
    logic [TO_W-1:0] to_cnt;
    logic [2:0]      req_f3;
    logic [1:0]      req_off;
    logic            fault;
    logic            timeout_hit;
    logic [3:0]      st_be;
    logic [31:0]     st_wdata;
    logic [31:0]     ld_data;

    assign fault       = is_fault(funct3, addr[1:0]);
    assign timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);

    // Load formatting uses the captured offset/funct3 so it does not depend on core inputs during BUS.
    lsu_lane_align u_align (
        .st_f3    (funct3),
        .st_off   (addr[1:0]),
        .st_data  (wdata),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_f3    (req_f3),
        .ld_off   (req_off),
        .ld_word  (bus_rdata),
        .ld_data  (ld_data)
    );

    always_comb begin
        stall    = 1'b0;
        misalign = 1'b0;
        case (state)
            ST_IDLE: begin
                stall    = mem_req && !fault;
                misalign = mem_req && fault;
            end
            ST_BUS:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            to_cnt    <= '0;
            req_f3    <= 3'd0;
            req_off   <= 2'd0;
            rdata     <= 32'd0;
            bus_err   <= 1'b0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_req && fault) begin
                        rdata <= 32'd0;
                    end else if (mem_req) begin
                        bus_valid <= 1'b1;
                        bus_we    <= mem_we;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= mem_we ? st_be : 4'b1111;
                        bus_wdata <= mem_we ? st_wdata : 32'd0;
                        req_f3    <= funct3;
                        req_off   <= addr[1:0];
                        to_cnt    <= '0;
                        state     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (bus_ready) begin
                        if (!bus_we) begin
                            rdata <= ld_data;
                        end
                        bus_valid <= 1'b0;
                        state     <= ST_DONE;
                    end else if (timeout_hit) begin
                        rdata     <= 32'd0;
                        bus_err   <= 1'b1;
                        bus_valid <= 1'b0;
                        state     <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Randomized scoreboard bench for lsu_bus_bridge: driver pushes expected outcomes, a negedge monitor pops and compares.
module tb_lsu_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    lsu_bus_bridge #(.TIMEOUT(16), .TO_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    // kind: 0 = completed on bus, 1 = fault (misalign), 2 = timeout abort
    typedef struct {
        int          kind;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rdata = 32'd0;
    exp_t        me;
    bit          m_pend = 1'b0;
    logic [31:0] m_pv = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s act=%08h exp=%08h t=%0t", name, act, want, $time);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    // Reference model: access size and byte arithmetic, independent of how the RTL steers lanes.
    task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rword, input int delay);
        exp_t        e;
        int          sz, off, exp_stalls, stalls, vcnt;
        bit          done;
        logic [63:0] v, mask;
        sz      = acc_size(f3);
        off     = int'(a[1:0]);
        e.we    = we;
        e.addr  = {a[31:2], 2'b00};
        e.be    = 4'd0;
        e.wdata = 32'd0;
        if (sz == 0 || (off % sz) != 0) begin
            e.kind      = 1;
            model_rdata = 32'd0;
            exp_stalls  = 0;
        end else begin
            if (we) begin
                for (int i = off; i < off + sz; i++) e.be[i] = 1'b1;
                for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
            end else begin
                e.be = 4'b1111;
            end
            if (delay >= 16) begin
                e.kind      = 2;
                model_rdata = 32'd0;
                exp_stalls  = 17;
            end else begin
                e.kind     = 0;
                exp_stalls = 2 + delay;
                if (!we) begin
                    mask = (64'd1 << (8 * sz)) - 64'd1;
                    v    = ({32'd0, rword} >> (8 * off)) & mask;
                    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
                    model_rdata = v[31:0];
                end
            end
        end
        e.rdata = model_rdata;
        q.push_back(e);

        mem_req   = 1'b1;
        mem_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        bus_ready = 1'b0;
        bus_rdata = rword;
        vcnt      = 0;
        stalls    = 0;
        done      = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
            if (bus_valid) begin
                bus_ready = (vcnt == delay);
                vcnt++;
            end else begin
                bus_ready = 1'b0;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL stall_budget act=stuck exp=release t=%0t", $time);
        end
        chk("stall_cycles", stalls, exp_stalls);
        @(posedge clk);
        #1;
        mem_req   = 1'b0;
        bus_ready = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (m_pend) begin
                    chk("rdata", rdata, m_pv);
                    m_pend = 1'b0;
                end
                if (misalign || (bus_valid && bus_ready) || bus_err) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event act=%b%b%b exp=none t=%0t",
                                 misalign, bus_valid && bus_ready, bus_err, $time);
                    end else begin
                        me = q.pop_front();
                        if (misalign) begin
                            chk("fault_kind", me.kind, 1);
                            chk("fault_stall", stall, 0);
                            chk("fault_bus_valid", bus_valid, 0);
                            m_pend = 1'b1;
                            m_pv   = me.rdata;
                        end else if (bus_err) begin
                            chk("timeout_kind", me.kind, 2);
                            chk("timeout_rdata", rdata, me.rdata);
                            chk("timeout_bus_valid", bus_valid, 0);
                            chk("timeout_addr", bus_addr, me.addr);
                        end else begin
                            chk("bus_kind", me.kind, 0);
                            chk("bus_we", bus_we, me.we);
                            chk("bus_addr", bus_addr, me.addr);
                            chk("bus_be", bus_be, me.be);
                            if (me.we) chk("bus_wdata", bus_wdata, me.wdata);
                            m_pend = 1'b1;
                            m_pv   = me.rdata;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_bus_valid"}, bus_valid, 0);
        chk({tag, "_bus_we"}, bus_we, 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_be"}, bus_be, 0);
        chk({tag, "_bus_wdata"}, bus_wdata, 0);
        chk({tag, "_misalign"}, misalign, 0);
        chk({tag, "_bus_err"}, bus_err, 0);
        chk({tag, "_stall"}, stall, 0);
    endtask

    logic [2:0] st_f3_tab [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

    initial begin : stim
        bit          we;
        logic [2:0]  f3;
        int          r, delay;
        reset     = 1'b1;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        funct3    = 3'd0;
        addr      = 32'd0;
        wdata     = 32'd0;
        bus_ready = 1'b0;
        bus_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;

        run_txn(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 0);
        run_txn(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'd0, 0);
        run_txn(1'b0, 3'b000, 32'h0000_0102, 32'd0, 32'h0080_0000, 1);
        run_txn(1'b0, 3'b100, 32'h0000_0102, 32'd0, 32'h0080_0000, 2);
        run_txn(1'b0, 3'b001, 32'h0000_0101, 32'd0, 32'hFFFF_FFFF, 0);
        run_txn(1'b0, 3'b010, 32'h0000_0200, 32'd0, 32'h1234_5678, 99);
        run_txn(1'b0, 3'b101, 32'h0000_0202, 32'd0, 32'h8001_7FFF, 0);
        run_txn(1'b1, 3'b001, 32'h0000_0206, 32'h0000_BEEF, 32'd0, 3);

        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? st_f3_tab[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 19);
            delay = (r == 0) ? 99 : (r % 5);
            run_txn(we, f3, $urandom, $urandom, $urandom, delay);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        // Reset lands in the second BUS cycle of a load whose slave never answers.
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h0000_0300;
        bus_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_reset_bus_valid", bus_valid, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");

        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
